// File: rtl/result_bus_arbiter_pkg.sv
// Shared types, sizes and helpers for the result broadcast bus arbiter and its
// per-producer result FIFOs.
package result_bus_arbiter_pkg;

    localparam int ROB_ID_W          = 4;
    localparam int WORD_W            = 32;
    localparam int RESULT_FIFO_DEPTH = 4;

    typedef logic [ROB_ID_W-1:0]                    ro_buffer_id_t;
    typedef logic [$clog2(RESULT_FIFO_DEPTH):0]     result_fifo_cnt_t;

    // Round-robin pointer encoding: which producer won the most recent grant.
    localparam logic GRANT_ALU = 1'b0;
    localparam logic GRANT_LSB = 1'b1;

    typedef struct packed {
        ro_buffer_id_t     dest;
        logic [WORD_W-1:0] value;
        logic [WORD_W-1:0] next_pc;
    } result_entry_t;

    localparam int RESULT_ENTRY_W = $bits(result_entry_t);

    // Tag 0 is reserved to mean "no result".
    function automatic logic tag_valid(input ro_buffer_id_t dest);
        return dest != '0;
    endfunction

endpackage

// File: rtl/result_fifo.sv
// Small private result FIFO for one producer; head is presented combinationally
// and a push into a full FIFO is accepted only when the head is popped that cycle.
module result_fifo #(
    parameter  int DEPTH  = 4,
    parameter  int DATA_W = 68,
    localparam int PTR_W  = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] data,
    output logic [DATA_W-1:0] head,
    output logic [PTR_W:0]    count
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic              full;
    logic              do_push;
    logic              do_pop;

    assign full    = (count == (PTR_W+1)'(DEPTH));
    assign do_pop  = pop && (count != '0) && !flush;
    assign do_push = push && (!full || do_pop) && !flush;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + (PTR_W+1)'(do_push) - (PTR_W+1)'(do_pop);
        end
    end

    // Storage carries no reset; validity is tracked purely by count.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= data;
    end

endmodule

// File: rtl/result_bus_arbiter.sv
// Round-robin arbiter sharing the result broadcast bus between the ALU path
// and the load/store buffer, with pre-full stall and ROB flush support.
module result_bus_arbiter
    import result_bus_arbiter_pkg::*;
#(
    parameter  int DEPTH = RESULT_FIFO_DEPTH,
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                rdy,
    input  logic                reset_from_rob_bus,
    input  ro_buffer_id_t       alu_dest,
    input  logic [WORD_W-1:0]   alu_value,
    input  logic [WORD_W-1:0]   alu_next_pc,
    input  ro_buffer_id_t       lsb_dest,
    input  logic [WORD_W-1:0]   lsb_value,
    output logic                alu_stall,
    output logic                lsb_stall,
    output ro_buffer_id_t       bus_dest,
    output logic [WORD_W-1:0]   bus_value,
    output logic [WORD_W-1:0]   bus_next_pc,
    output logic                bus_from_lsb,
    output logic                overflow_err
);

    result_entry_t    alu_entry;
    result_entry_t    lsb_entry;
    result_entry_t    alu_head;
    result_entry_t    lsb_head;
    result_entry_t    win_entry;
    logic [CNT_W-1:0] alu_count;
    logic [CNT_W-1:0] lsb_count;
    logic             flush;
    logic             alu_push;
    logic             lsb_push;
    logic             alu_pop;
    logic             lsb_pop;
    logic             alu_ne;
    logic             lsb_ne;
    logic             grant_vld;
    logic             grant_lsb;
    logic             last_grant;
    logic             overflow_hit;

    assign alu_entry = '{dest: alu_dest, value: alu_value, next_pc: alu_next_pc};
    assign lsb_entry = '{dest: lsb_dest, value: lsb_value, next_pc: '0};

    // A frozen cycle ignores flush and pushes alike.
    assign flush    = rdy && reset_from_rob_bus;
    assign alu_push = rdy && !reset_from_rob_bus && tag_valid(alu_dest);
    assign lsb_push = rdy && !reset_from_rob_bus && tag_valid(lsb_dest);

    assign alu_ne = (alu_count != '0);
    assign lsb_ne = (lsb_count != '0);

    always_comb begin
        grant_lsb = 1'b0;
        if (alu_ne && lsb_ne) begin
            grant_lsb = (last_grant == GRANT_ALU);
        end else if (lsb_ne) begin
            grant_lsb = 1'b1;
        end
    end

    assign grant_vld = rdy && !reset_from_rob_bus && (alu_ne || lsb_ne);
    assign alu_pop   = grant_vld && !grant_lsb;
    assign lsb_pop   = grant_vld && grant_lsb;
    assign win_entry = grant_lsb ? lsb_head : alu_head;

    // Stall one entry early so the producer's one-cycle reaction still fits.
    assign alu_stall = (alu_count >= CNT_W'(DEPTH - 1));
    assign lsb_stall = (lsb_count >= CNT_W'(DEPTH - 1));

    assign overflow_hit = (alu_push && (alu_count == CNT_W'(DEPTH)) && !alu_pop) ||
                          (lsb_push && (lsb_count == CNT_W'(DEPTH)) && !lsb_pop);

    result_fifo #(
        .DEPTH  (DEPTH),
        .DATA_W (RESULT_ENTRY_W)
    ) u_alu_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .push  (alu_push),
        .pop   (alu_pop),
        .data  (alu_entry),
        .head  (alu_head),
        .count (alu_count)
    );

    result_fifo #(
        .DEPTH  (DEPTH),
        .DATA_W (RESULT_ENTRY_W)
    ) u_lsb_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .push  (lsb_push),
        .pop   (lsb_pop),
        .data  (lsb_entry),
        .head  (lsb_head),
        .count (lsb_count)
    );

    // last_grant resets to LSB so the ALU wins the first contended cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant <= GRANT_LSB;
        end else if (flush) begin
            last_grant <= GRANT_LSB;
        end else if (grant_vld) begin
            last_grant <= grant_lsb ? GRANT_LSB : GRANT_ALU;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow_err <= 1'b0;
        end else if (overflow_hit) begin
            overflow_err <= 1'b1;
        end
    end

    // Bus registers return to zero on every non-grant cycle: one-cycle pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus_dest     <= '0;
            bus_value    <= '0;
            bus_next_pc  <= '0;
            bus_from_lsb <= 1'b0;
        end else if (grant_vld) begin
            bus_dest     <= win_entry.dest;
            bus_value    <= win_entry.value;
            bus_next_pc  <= win_entry.next_pc;
            bus_from_lsb <= grant_lsb;
        end else begin
            bus_dest     <= '0;
            bus_value    <= '0;
            bus_next_pc  <= '0;
            bus_from_lsb <= 1'b0;
        end
    end

endmodule

// File: tb/tb_result_bus_arbiter.sv
// Directed bench for result_bus_arbiter (DEPTH=4): basic path, alternation,
// fill/stall/overflow, wrap-around, flush, freeze and asynchronous reset.
module tb_result_bus_arbiter;
    import result_bus_arbiter_pkg::*;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          rdy;
    logic          reset_from_rob_bus;
    ro_buffer_id_t alu_dest;
    logic [31:0]   alu_value;
    logic [31:0]   alu_next_pc;
    ro_buffer_id_t lsb_dest;
    logic [31:0]   lsb_value;
    logic          alu_stall;
    logic          lsb_stall;
    ro_buffer_id_t bus_dest;
    logic [31:0]   bus_value;
    logic [31:0]   bus_next_pc;
    logic          bus_from_lsb;
    logic          overflow_err;

    int total = 0;
    int bad   = 0;

    // Expected bus sequence for the fill/overflow scenario, edges 2..17.
    logic [31:0] fill_val [16] = '{32'hA1, 32'hB1, 32'hA2, 32'hB2, 32'hA3, 32'hB3, 32'hA4, 32'hB4,
                                   32'hA5, 32'hB5, 32'hA6, 32'hB6, 32'hA7, 32'hB7, 32'hA8, 32'h0};
    logic        fill_lsb [16] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1,
                                   1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    logic [31:0] fill_pc  [16] = '{32'h301, 32'h0, 32'h302, 32'h0, 32'h303, 32'h0, 32'h304, 32'h0,
                                   32'h305, 32'h0, 32'h306, 32'h0, 32'h307, 32'h0, 32'h308, 32'h0};

    result_bus_arbiter #(.DEPTH(4)) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .rdy                (rdy),
        .reset_from_rob_bus (reset_from_rob_bus),
        .alu_dest           (alu_dest),
        .alu_value          (alu_value),
        .alu_next_pc        (alu_next_pc),
        .lsb_dest           (lsb_dest),
        .lsb_value          (lsb_value),
        .alu_stall          (alu_stall),
        .lsb_stall          (lsb_stall),
        .bus_dest           (bus_dest),
        .bus_value          (bus_value),
        .bus_next_pc        (bus_next_pc),
        .bus_from_lsb       (bus_from_lsb),
        .overflow_err       (overflow_err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        alu_dest    = '0;
        alu_value   = '0;
        alu_next_pc = '0;
        lsb_dest    = '0;
        lsb_value   = '0;
        reset_from_rob_bus = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
    endtask

    initial begin
        rdy = 1'b1;
        idle_inputs();
        rst_n = 1'b0;
        #1;
        chk("rst_bus_dest", 32'(bus_dest), 32'h0);
        chk("rst_bus_value", bus_value, 32'h0);
        chk("rst_bus_next_pc", bus_next_pc, 32'h0);
        chk("rst_bus_from_lsb", 32'(bus_from_lsb), 32'h0);
        chk("rst_alu_stall", 32'(alu_stall), 32'h0);
        chk("rst_lsb_stall", 32'(lsb_stall), 32'h0);
        chk("rst_overflow", 32'(overflow_err), 32'h0);
        cyc();
        rst_n = 1'b1;

        // Basic ALU path
        alu_dest = 4'd3; alu_value = 32'h11; alu_next_pc = 32'h104;
        cyc();
        idle_inputs();
        chk("basic_no_bypass", 32'(bus_dest), 32'h0);
        cyc();
        chk("basic_dest", 32'(bus_dest), 32'h3);
        chk("basic_value", bus_value, 32'h11);
        chk("basic_next_pc", bus_next_pc, 32'h104);
        chk("basic_from_lsb", 32'(bus_from_lsb), 32'h0);
        cyc();
        chk("basic_pulse_end", 32'(bus_dest), 32'h0);

        // Simultaneous pushes from reset, twice
        do_reset();
        for (int p = 0; p < 2; p++) begin
            alu_dest = 4'd1; alu_value = 32'hA1; alu_next_pc = 32'h200;
            lsb_dest = 4'd2; lsb_value = 32'hB2;
            cyc();
            idle_inputs();
            cyc();
            chk("sim_first_dest", 32'(bus_dest), 32'h1);
            chk("sim_first_pc", bus_next_pc, 32'h200);
            chk("sim_first_lsb", 32'(bus_from_lsb), 32'h0);
            cyc();
            chk("sim_second_dest", 32'(bus_dest), 32'h2);
            chk("sim_second_value", bus_value, 32'hB2);
            chk("sim_second_pc", bus_next_pc, 32'h0);
            chk("sim_second_lsb", 32'(bus_from_lsb), 32'h1);
        end
        cyc();
        chk("sim_idle", 32'(bus_dest), 32'h0);

        // Fill, stall and overflow under continuous contention
        do_reset();
        for (int e = 1; e <= 17; e++) begin
            if (e <= 8) begin
                alu_dest = 4'd1; alu_value = 32'hA0 + 32'(e); alu_next_pc = 32'h300 + 32'(e);
                lsb_dest = 4'd2; lsb_value = 32'hB0 + 32'(e);
            end else begin
                idle_inputs();
            end
            cyc();
            if (e >= 2) begin
                chk($sformatf("fill_value_e%0d", e), bus_value, fill_val[e-2]);
                chk($sformatf("fill_lsb_e%0d", e), 32'(bus_from_lsb), 32'(fill_lsb[e-2]));
                chk($sformatf("fill_pc_e%0d", e), bus_next_pc, fill_pc[e-2]);
            end
            if (e == 3) chk("fill_lsb_stall_lo", 32'(lsb_stall), 32'h0);
            if (e == 4) chk("fill_lsb_stall_hi", 32'(lsb_stall), 32'h1);
            if (e == 4) chk("fill_alu_stall_lo", 32'(alu_stall), 32'h0);
            if (e == 5) chk("fill_alu_stall_hi", 32'(alu_stall), 32'h1);
            if (e == 7) chk("fill_overflow_lo", 32'(overflow_err), 32'h0);
            if (e == 8) chk("fill_overflow_hi", 32'(overflow_err), 32'h1);
        end
        chk("fill_overflow_sticky", 32'(overflow_err), 32'h1);

        // Wrap-around: ten back-to-back ALU results
        do_reset();
        chk("reset_clears_overflow", 32'(overflow_err), 32'h0);
        for (int i = 1; i <= 10; i++) begin
            alu_dest = 4'(i); alu_value = 32'h100 + 32'(i); alu_next_pc = 32'h0;
            cyc();
            chk($sformatf("wrap_stall_%0d", i), 32'(alu_stall), 32'h0);
            if (i > 1) chk($sformatf("wrap_dest_%0d", i - 1), 32'(bus_dest), 32'(i - 1));
        end
        idle_inputs();
        cyc();
        chk("wrap_dest_10", 32'(bus_dest), 32'hA);
        chk("wrap_value_10", bus_value, 32'h10A);
        cyc();
        chk("wrap_idle", 32'(bus_dest), 32'h0);

        // Flush with two entries queued per producer
        for (int k = 0; k < 3; k++) begin
            alu_dest = 4'(1 + k); alu_value = 32'hC0 + 32'(k); alu_next_pc = 32'h400;
            lsb_dest = 4'(4 + k); lsb_value = 32'hD0 + 32'(k);
            cyc();
        end
        chk("flush_pre_dest", 32'(bus_dest), 32'h1);
        chk("flush_pre_alu_stall", 32'(alu_stall), 32'h0);
        reset_from_rob_bus = 1'b1;
        alu_dest = 4'd7; lsb_dest = 4'd8;
        cyc();
        idle_inputs();
        chk("flush_bus_zero", 32'(bus_dest), 32'h0);
        chk("flush_alu_stall", 32'(alu_stall), 32'h0);
        chk("flush_lsb_stall", 32'(lsb_stall), 32'h0);
        cyc();
        chk("flush_stays_empty", 32'(bus_dest), 32'h0);
        alu_dest = 4'd9;  alu_value = 32'h99; alu_next_pc = 32'h999;
        lsb_dest = 4'd10; lsb_value = 32'hAA;
        cyc();
        idle_inputs();
        cyc();
        chk("flush_alu_first", 32'(bus_dest), 32'h9);
        chk("flush_alu_pc", bus_next_pc, 32'h999);
        cyc();
        chk("flush_lsb_second", 32'(bus_dest), 32'hA);
        chk("flush_lsb_flag", 32'(bus_from_lsb), 32'h1);
        cyc();
        chk("flush_done_idle", 32'(bus_dest), 32'h0);

        // Freeze with a queued entry; ignored pushes and flush while frozen
        alu_dest = 4'd5; alu_value = 32'h55; alu_next_pc = 32'h555;
        cyc();
        rdy = 1'b0;
        alu_dest = 4'd6; alu_value = 32'h66;
        lsb_dest = 4'd3; lsb_value = 32'h33;
        reset_from_rob_bus = 1'b1;
        for (int f = 0; f < 3; f++) begin
            cyc();
            chk($sformatf("freeze_bus_%0d", f), 32'(bus_dest), 32'h0);
        end
        rdy = 1'b1;
        idle_inputs();
        cyc();
        chk("thaw_dest", 32'(bus_dest), 32'h5);
        chk("thaw_value", bus_value, 32'h55);
        cyc();
        chk("thaw_nothing_else", 32'(bus_dest), 32'h0);

        // Asynchronous reset mid-cycle
        alu_dest = 4'd4; alu_value = 32'h44; alu_next_pc = 32'h444;
        cyc();
        idle_inputs();
        cyc();
        chk("pre_async_dest", 32'(bus_dest), 32'h4);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_dest", 32'(bus_dest), 32'h0);
        chk("async_value", bus_value, 32'h0);
        chk("async_next_pc", bus_next_pc, 32'h0);
        chk("async_from_lsb", 32'(bus_from_lsb), 32'h0);
        cyc();
        rst_n = 1'b1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/result_bus_arbiter.md
# result_bus_arbiter

Shares the single result broadcast bus between the two result producers: the reservation-station ALU path and the load/store buffer. Each producer pushes completed results into a small private FIFO. A registered round-robin arbiter then drains one entry per cycle onto the bus. The bus feeds the reorder buffer, the reservation station wakeup logic and the issuer. The arbiter also applies early-stall backpressure to each producer and discards all queued results on a reorder-buffer flush.

## Interface
- `DEPTH`, default 4: entries per producer FIFO (power of two, ≥2).
- `clk` input 1: clock; all state updates on rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `rdy` input 1: global enable; when low, state is frozen.
- `reset_from_rob_bus` input 1: synchronous flush.
- `alu_dest` input `RO_BUFFER_ID_TYPE`: ALU result tag; 0 = no result this cycle.
- `alu_value` input 32: ALU result.
- `alu_next_pc` input 32: ALU next pc.
- `lsb_dest` input `RO_BUFFER_ID_TYPE`: load/store result tag; 0 = none.
- `lsb_value` input 32: load/store result.
- `alu_stall` output 1: ALU producer must not push next cycle.
- `lsb_stall` output 1: load/store producer must not push next cycle.
- `bus_dest` output `RO_BUFFER_ID_TYPE`: broadcast tag; 0 = bus idle.
- `bus_value` output 32: broadcast value.
- `bus_next_pc` output 32: broadcast next pc; 0 for load/store results.
- `bus_from_lsb` output 1: 1 when the broadcast came from the load/store buffer.
- `overflow_err` output 1: sticky; a push arrived while that FIFO was full.

## Operation
- **Push:** any nonzero `*_dest` pushes `{dest, value, next_pc}` into that producer's FIFO. Load/store entries store `next_pc = 0`.
- **Grant eligibility:** each cycle at most one non-empty FIFO is granted. Its head is popped and registered onto the bus outputs.
- **Round-robin:** pointer `last_grant` is 0 for ALU and 1 for LSB.
  - Both FIFOs non-empty: grant the one opposite `last_grant`.
  - Exactly one non-empty: grant it.
  - `last_grant` updates to the winner on every grant.
- **No grant:** all bus outputs register to 0.
- **Stall:** `*_stall` = (count ≥ DEPTH−1), combinational from count. This is a pre-full policy that absorbs the one cycle of producer reaction delay.
- **Overflow:** a push into a FIFO whose count is DEPTH and which is not popped that cycle is dropped. `overflow_err` sets and is cleared only by `rst_n`.
- **Same-cycle push and pop:** allowed on the same FIFO, including a full one; count is unchanged and no overflow occurs.
- **Wrap-around:** read and write pointers are log2(DEPTH) bits and wrap naturally. Count is log2(DEPTH)+1 bits.
- **Flush:** `reset_from_rob_bus` high at an edge (with `rdy` high) has these effects:
  - clears both FIFOs, counts and pointers;
  - sets `last_grant` to 1;
  - zeroes bus outputs;
  - drops that cycle's pushes;
  - leaves `overflow_err` unchanged.
- **`rdy` low:** no push, no pop and no pointer update; inputs are ignored.
  - Bus outputs register to 0, so no broadcast repeats.
  - Flush is also ignored.

## Timing
- **Reset (`rst_n` low):** asynchronous. All outputs are 0 immediately, except `alu_stall`/`lsb_stall`, which are 0 because count is 0. FIFOs are empty and `last_grant` is 1 (ALU first).
- **Latency:** a result pushed at edge N into an empty FIFO with no competitor appears on the bus after edge N+1. There is no same-cycle bypass.
- **Throughput:** one broadcast per cycle total. Under continuous contention, each producer gets every other cycle.
- **Stall reaction:** `*_stall` rises in the cycle after the push that brings count to DEPTH−1. One further push is tolerated.
- **Bus pulse width:** each bus value is valid for exactly one cycle.
- **Flush timing:** the bus is 0 in the cycle after the flush edge. A flush during a grant cycle suppresses that grant.

## Structure
- `RO_BUFFER_ID_TYPE` and `REG_TYPE` come from `config.v`. Add `RESULT_FIFO_DEPTH` and `RESULT_FIFO_CNT_TYPE` there.
- One sub-module, `result_fifo`:
  - parameterised on DEPTH and data width;
  - ports: push, pop, data in, head out, count, flush;
  - instantiated twice (ALU and LSB).
- Arbitration, `last_grant` and the output registers live in the top module.

## Test plan
- **Basic ALU path:** `rst_n` pulse, then ALU push dest=3, value=0x11, next_pc=0x104 → next cycle the bus shows dest=3, value=0x11, next_pc=0x104, from_lsb=0; the following cycle dest=0.
- **Simultaneous pushes:** ALU dest=1 and LSB dest=2 in the same cycle from reset → bus shows dest=1, then dest=2 (from_lsb=1, next_pc=0). A second simultaneous pair gives dest 1/2 again (alternation holds).
- **Fill and stall (DEPTH=4):** 3 LSB pushes with an ALU stream competing → `lsb_stall` is 1 after the third push. A 4th push is accepted; a 5th with no pop sets `overflow_err`=1 and that entry never appears.
- **Wrap-around:** push 10 ALU results, dest=1..10, one per cycle with no competition → bus emits 1..10 in order, each one cycle later; `alu_stall` stays 0.
- **Flush:** with 2 entries queued in each FIFO, assert `reset_from_rob_bus` for one cycle → bus is 0 thereafter, both stalls are 0, and the next ALU push broadcasts first.
- **Freeze and async reset:** `rdy`=0 for 3 cycles with a queued entry → bus is 0 and the entry stays queued; with `rdy`=1 it broadcasts. Then drop `rst_n` mid-cycle → outputs go to 0 without waiting for a clock edge.
